alu_arbiter: RTL

- Shares the single 8-bit ALU between two requesters (req 0, req 1) using a round-robin arbiter and a 3-state sequencer.
- Accepts one operation at a time over a valid/ready handshake and drives the ALU operand and opcode ports from registered values.
- Captures the result and compare bit (CB) and returns them over a response valid/ready handshake tagged with the requester ID.
- Sits between the decode/issue stages and the ALU instance.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_arbiter_rr_arb2.sv | 11 +
 rtl/alu_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, sequencer states and opcode helpers shared by the ALU arbiter
// Contents: OP_* opcode encodings, st_e sequencer state enum, is_cmp_op() compare-op test.
package alu_pkg;
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SLL = 3'b010;
   localparam logic [2:0] OP_SRL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_ABS = 3'b110;
   localparam logic [2:0] OP_SEQ = 3'b111;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} st_e;
   function automatic logic is_cmp_op(input logic [2:0] op);
      return (op == OP_SLT) || (op == OP_SEQ);
   endfunction
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant, reusable for any shared resource
// Ports: i_valid (per-requester valid), i_last (requester granted last), o_gnt (one-hot or zero grant).
module rr_arb2 (
   input  logic [1:0] i_valid,
   input  logic       i_last,
   output logic [1:0] o_gnt
);
   // On a tie the requester that did not win last time is granted.
   assign o_gnt[0] = i_valid[0] & (~i_valid[1] | i_last);
   assign o_gnt[1] = i_valid[1] & (~i_valid[0] | ~i_last);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with round-robin grant and an IDLE/EXEC/RESP sequencer
// Ports: clk_i/rst_n_i (async active-low reset); req_valid_i/req_ready_o plus req0_*/req1_* request fields;
//        alu_opcode_o/alu_rs_o/alu_rt_o drive the ALU, alu_result_i/alu_zero_i come back from it;
//        resp_valid_o/resp_ready_i/resp_id_o/resp_result_o/resp_cb_o form the tagged response.
// Optional: define ALU_ARB_PERF_EN to add grant_cnt0_o/grant_cnt1_o saturating grant counters and perf_clr_i.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = 8,
`ifdef ALU_ARB_PERF_EN
   parameter int PERF_W = 16,
`endif
   parameter int OP_W   = 3
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [1:0]        req_valid_i,
   output logic [1:0]        req_ready_o,
   input  logic [OP_W-1:0]   req0_opcode_i,
   input  logic [DATA_W-1:0] req0_rs_i,
   input  logic [DATA_W-1:0] req0_rt_i,
   input  logic [OP_W-1:0]   req1_opcode_i,
   input  logic [DATA_W-1:0] req1_rs_i,
   input  logic [DATA_W-1:0] req1_rt_i,
   output logic [OP_W-1:0]   alu_opcode_o,
   output logic [DATA_W-1:0] alu_rs_o,
   output logic [DATA_W-1:0] alu_rt_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              alu_zero_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic              resp_id_o,
   output logic [DATA_W-1:0] resp_result_o,
`ifdef ALU_ARB_PERF_EN
   input  logic              perf_clr_i,
   output logic [PERF_W-1:0] grant_cnt0_o,
   output logic [PERF_W-1:0] grant_cnt1_o,
`endif
   output logic              resp_cb_o
);
   st_e               r_state;
   logic              r_last;
   logic [OP_W-1:0]   r_op;
   logic [DATA_W-1:0] r_rs;
   logic [DATA_W-1:0] r_rt;
   logic              r_valid;
   logic              r_id;
   logic [DATA_W-1:0] r_result;
   logic              r_cb;
   logic [1:0]        w_gnt;
   logic              w_cmp;
   rr_arb2 u_arb (
      .i_valid (req_valid_i),
      .i_last  (r_last),
      .o_gnt   (w_gnt)
   );
   assign req_ready_o   = (r_state == IDLE) ? w_gnt : 2'b00;
   assign w_cmp         = is_cmp_op(r_op);
   assign alu_opcode_o  = r_op;
   assign alu_rs_o      = r_rs;
   assign alu_rt_o      = r_rt;
   assign resp_valid_o  = r_valid;
   assign resp_id_o     = r_id;
   assign resp_result_o = r_result;
   assign resp_cb_o     = r_cb;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state  <= IDLE;
         r_last   <= 1'b1;
         r_op     <= '0;
         r_rs     <= '0;
         r_rt     <= '0;
         r_valid  <= 1'b0;
         r_id     <= 1'b0;
         r_result <= '0;
         r_cb     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (|w_gnt) begin
               r_op    <= w_gnt[1] ? req1_opcode_i : req0_opcode_i;
               r_rs    <= w_gnt[1] ? req1_rs_i : req0_rs_i;
               r_rt    <= w_gnt[1] ? req1_rt_i : req0_rt_i;
               r_id    <= w_gnt[1];
               r_last  <= w_gnt[1];
               r_state <= EXEC;
            end
            EXEC: begin
               // Compare ops report through the CB register and return a zero result.
               r_result <= w_cmp ? '0 : alu_result_i;
               r_cb     <= w_cmp ? alu_zero_i : r_cb;
               r_valid  <= 1'b1;
               r_state  <= RESP;
            end
            RESP: if (resp_ready_i) begin
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
`ifdef ALU_ARB_PERF_EN
   logic [PERF_W-1:0] r_cnt0;
   logic [PERF_W-1:0] r_cnt1;
   assign grant_cnt0_o = r_cnt0;
   assign grant_cnt1_o = r_cnt1;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (perf_clr_i) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         r_cnt0 <= (req_ready_o[0] && !(&r_cnt0)) ? r_cnt0 + 1'b1 : r_cnt0;
         r_cnt1 <= (req_ready_o[1] && !(&r_cnt1)) ? r_cnt1 + 1'b1 : r_cnt1;
      end
   end
`endif
endmodule
